interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter VECTOR_BASE, default 20'h00100, meaning handler address for hardInterrupt[0].
REQ-002 Parameter VECTOR_STRIDE, default 20'h00010, meaning address spacing between consecutive handler vectors.
REQ-003 Parameter MASK_RESET, default 4'hF, meaning mask value loaded at reset (1 = enabled).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-006 rstIn  in  1  reset; asynchronous, active-high.
REQ-007 hardInterrupt  in  4  external interrupt lines, asynchronous, rising-edge sensitive.
REQ-008 maskWe  in  1  writes maskIn into the mask register.
REQ-009 maskIn  in  4  new mask value.
REQ-010 maskOut  out  4  current mask register.
REQ-011 irqReq  out  1  interrupt request to the CPU.
REQ-012 irqAck  in  1  CPU acknowledge, one-cycle pulse.
REQ-013 iret  in  1  CPU return-from-interrupt, one-cycle pulse.
REQ-014 irqId  out  2  index of the granted line.
REQ-015 irqVector  out  20  handler address for irqId.
REQ-016 pending  out  4  latched, not-yet-acknowledged edges.
REQ-017 inService  out  1  high while a handler runs.

Function
REQ-018 Each hardInterrupt bit SHALL pass through a 2-flop synchronizer, followed by a third flop for edge detection.
REQ-019 A 0->1 transition on the synchronized line SHALL set pending[i] at the 3rd rising clk edge after the input rises (input held high for at least 2 cycles).
REQ-020 Level-high inputs SHALL NOT re-set pending after it clears; only a new rising edge SHALL set pending.
REQ-021 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-022 In IDLE, when (pending & maskOut) != 0, the FSM SHALL latch irqId = the lowest set index (bit 0 is highest priority) and enter REQ at the next edge.
REQ-023 In REQ, irqReq SHALL be 1, and irqId and irqVector SHALL be held stable.
REQ-024 Priority SHALL be decided only at the IDLE->REQ transition; a higher-priority edge arriving while in REQ SHALL NOT change irqId.
REQ-025 A mask change during REQ SHALL NOT retract irqReq.
REQ-026 When irqAck is high in REQ, pending[irqId] SHALL clear, irqReq SHALL drop and the FSM SHALL enter SERVICE, all at the same edge.
REQ-027 irqAck in IDLE or SERVICE SHALL be ignored.
REQ-028 In SERVICE, inService SHALL be 1 and no new request SHALL be raised (no nesting); pending SHALL continue to collect edges.
REQ-029 When iret is high in SERVICE, the FSM SHALL return to IDLE.
REQ-030 iret in IDLE or REQ SHALL be ignored.
REQ-031 From SERVICE->IDLE, a remaining pending&mask SHALL raise irqReq one cycle later (minimum one idle cycle between services).
REQ-032 irqVector SHALL equal (VECTOR_BASE + irqId*VECTOR_STRIDE) mod 2^20 and SHALL wrap silently on overflow.
REQ-033 A new edge and a clear of the same pending bit in the same cycle SHALL leave the bit set.
REQ-034 A masked line SHALL still latch pending and SHALL be requested once unmasked.
REQ-035 maskWe SHALL update the mask at the next edge in every state.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 While rstIn = 1, the outputs SHALL be: irqReq = 0, inService = 0, irqId = 0, irqVector = VECTOR_BASE, pending = 0, maskOut = MASK_RESET.
REQ-038 While rstIn = 1, the FSM SHALL be in IDLE and all synchronizer and edge flops SHALL be 0.
REQ-039 Reset asserted mid-REQ or mid-SERVICE SHALL discard the request and all pending edges immediately, without waiting for a clock edge.
REQ-040 After reset release, a line already high SHALL NOT register as an edge.

Verification
REQ-041 The bench SHALL cover: hardInterrupt = 4'b0100 rising at cycle 0 -> pending = 4'b0100 at edge 3, irqReq = 1 at edge 4, irqId = 2, irqVector = 20'h00120.
REQ-042 The bench SHALL cover: simultaneous rise of 4'b1010 -> grant irqId = 1; after irqAck and iret, grant irqId = 3, with one idle cycle between.
REQ-043 The bench SHALL cover: maskIn = 4'b1110 written, then bit 0 rises -> pending[0] = 1 and irqReq = 0; write mask 4'hF -> irqReq = 1, irqId = 0.
REQ-044 The bench SHALL cover: bit 3 edge during SERVICE -> no irqReq until iret; then irqReq = 1 with irqId = 3.
REQ-045 The bench SHALL cover: rstIn pulsed while irqReq = 1 -> irqReq = 0 and pending = 0 immediately; line held high after release -> no request.
REQ-046 The bench SHALL cover: VECTOR_BASE = 20'hFFFF0 and irqId = 2 -> irqVector = 20'h00010.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt controller and the CPU.
// The CPU side drives the request inputs and the controller drives the status outputs.
interface interrupt_controller_if;
    logic [3:0]  hardInterrupt;
    logic        maskWe;
    logic [3:0]  maskIn;
    logic [3:0]  maskOut;
    logic        irqReq;
    logic        irqAck;
    logic        iret;
    logic [1:0]  irqId;
    logic [19:0] irqVector;
    logic [3:0]  pending;
    logic        inService;

    modport master (
        output hardInterrupt,
        output maskWe,
        output maskIn,
        output irqAck,
        output iret,
        input  maskOut,
        input  irqReq,
        input  irqId,
        input  irqVector,
        input  pending,
        input  inService
    );

    modport slave (
        input  hardInterrupt,
        input  maskWe,
        input  maskIn,
        input  irqAck,
        input  iret,
        output maskOut,
        output irqReq,
        output irqId,
        output irqVector,
        output pending,
        output inService
    );
endinterface

// File: rtl/interrupt_controller.sv
// Vectored 4-line interrupt controller: synchronized edge latching, fixed
// priority grant (line 0 highest) and a non-nesting request/service handshake.
module interrupt_controller #(
    parameter logic [19:0] VECTOR_BASE   = 20'h00100,
    parameter logic [19:0] VECTOR_STRIDE = 20'h00010,
    parameter logic [3:0]  MASK_RESET    = 4'hF
) (
    input  logic                  clk,
    input  logic                  rstIn,
    interrupt_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  edge_q, edge_d;
    logic [1:0]  warm_q, warm_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  irq_id_q, irq_id_d;
    logic [19:0] irq_vector_q, irq_vector_d;
    logic        irq_req_q, irq_req_d;
    logic        in_service_q, in_service_d;

    logic [3:0]  rise;
    logic [3:0]  active;
    logic [3:0]  clr;
    logic [1:0]  lowest;

    function automatic logic [19:0] vector_of(input logic [1:0] id);
        return VECTOR_BASE + VECTOR_STRIDE * {18'd0, id};
    endfunction

    // Edges are ignored until the synchronizer holds post-reset samples,
    // so a line already high at reset release is not seen as a rise.
    always_comb begin
        sync1_d = bus.hardInterrupt;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        rise    = (warm_q == 2'd3) ? (sync2_q & ~edge_q) : 4'b0000;
    end

    assign active = pending_q & mask_q;

    always_comb begin
        lowest = 2'd0;
        if (active[0])      lowest = 2'd0;
        else if (active[1]) lowest = 2'd1;
        else if (active[2]) lowest = 2'd2;
        else if (active[3]) lowest = 2'd3;
    end

    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        irq_vector_d = irq_vector_q;
        clr          = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d      = REQ;
                    irq_id_d     = lowest;
                    irq_vector_d = vector_of(lowest);
                end
            end
            REQ: begin
                if (bus.irqAck) begin
                    state_d = SERVICE;
                    clr     = 4'b0001 << irq_id_q;
                end
            end
            SERVICE: begin
                if (bus.iret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh rise wins over an acknowledge clear of the same bit.
    always_comb begin
        pending_d    = (pending_q & ~clr) | rise;
        mask_d       = bus.maskWe ? bus.maskIn : mask_q;
        irq_req_d    = (state_d == REQ);
        in_service_d = (state_d == SERVICE);
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state_q      <= IDLE;
            sync1_q      <= 4'b0000;
            sync2_q      <= 4'b0000;
            edge_q       <= 4'b0000;
            warm_q       <= 2'd0;
            pending_q    <= 4'b0000;
            mask_q       <= MASK_RESET;
            irq_id_q     <= 2'd0;
            irq_vector_q <= VECTOR_BASE;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            edge_q       <= edge_d;
            warm_q       <= warm_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            irq_id_q     <= irq_id_d;
            irq_vector_q <= irq_vector_d;
            irq_req_q    <= irq_req_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.maskOut   = mask_q;
    assign bus.pending   = pending_q;
    assign bus.irqReq    = irq_req_q;
    assign bus.irqId     = irq_id_q;
    assign bus.irqVector = irq_vector_q;
    assign bus.inService = in_service_q;

endmodule
